// File: rtl/mantissa_divider.sv
// Sequential radix-2 restoring divider for FP significands: QUOTIENT = floor(Xin*2^(q_nbit-1)/Yin),
// one quotient bit per cycle, with sticky, divide-by-zero and overflow flags.
module mantissa_divider #(
  parameter int input_nbit = 24,
  parameter int q_nbit     = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [input_nbit-1:0] Xin,
  input  logic [input_nbit-1:0] Yin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [q_nbit-1:0]     QUOTIENT,
  output logic                  sticky,
  output logic                  div_by_zero,
  output logic                  ovf
);

  localparam int CW = $clog2(q_nbit);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [q_nbit-1:0] quot;
    logic              sticky;
    logic              dbz;
    logic              ovf;
  } result_t;

  state_t                state_q, state_d;
  result_t               res_q;
  logic [input_nbit:0]   rem_q;
  logic [input_nbit-1:0] div_q;
  logic [CW-1:0]         cnt_q;

  logic                  y_zero, x_ovf;
  logic [input_nbit:0]   step_r, step_y, step_diff;
  logic                  step_ge;

  assign y_zero = (Yin == '0);
  assign x_ovf  = ({1'b0, Xin} >= {Yin, 1'b0});

  // One shared restoring step. In IDLE it runs on the raw operands so the
  // accept edge already produces the integer bit; that keeps normal latency
  // at q_nbit edges and throughput at q_nbit+1 cycles.
  assign step_r    = (state_q == IDLE) ? {1'b0, Xin} : rem_q;
  assign step_y    = (state_q == IDLE) ? {1'b0, Yin} : {1'b0, div_q};
  assign step_ge   = (step_r >= step_y);
  assign step_diff = step_ge ? (step_r - step_y) : step_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (y_zero || x_ovf) ? DONE : CALC;
      CALC: if (cnt_q == '0) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          div_q        <= Yin;
          res_q.sticky <= 1'b0;
          res_q.dbz    <= 1'b0;
          res_q.ovf    <= 1'b0;
          if (y_zero) begin
            res_q.quot <= '1;
            res_q.dbz  <= 1'b1;
          end else if (x_ovf) begin
            res_q.quot <= '1;
            res_q.ovf  <= 1'b1;
          end else begin
            res_q.quot <= {{(q_nbit-1){1'b0}}, step_ge};
            rem_q      <= step_diff << 1;
            cnt_q      <= CW'(q_nbit - 2);
          end
        end
        CALC: begin
          // R < 2Y is kept by every step, so the shift never loses a bit.
          res_q.quot <= {res_q.quot[q_nbit-2:0], step_ge};
          rem_q      <= step_diff << 1;
          cnt_q      <= cnt_q - 1'b1;
          if (cnt_q == '0) res_q.sticky <= |step_diff;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign QUOTIENT    = res_q.quot;
  assign sticky      = res_q.sticky;
  assign div_by_zero = res_q.dbz;
  assign ovf         = res_q.ovf;

endmodule

// File: tb/tb_mantissa_divider.sv
// Directed and randomized checks of mantissa_divider against hand values and a floor-division model.
module tb_mantissa_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [23:0] Xin, Yin;
  logic [25:0] QUOTIENT;
  logic        sticky, div_by_zero, ovf;

  int checks = 0;
  int errors = 0;

  mantissa_divider #(.input_nbit(24), .q_nbit(26)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Xin(Xin), .Yin(Yin), .out_valid(out_valid), .out_ready(out_ready),
    .QUOTIENT(QUOTIENT), .sticky(sticky), .div_by_zero(div_by_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Presents operands, waits for the accept edge, scrambles the inputs, then
  // counts edges (accept edge included) until out_valid; lat=100 on timeout.
  task automatic do_op(input logic [23:0] x, input logic [23:0] y, output int lat);
    @(negedge clk);
    in_valid = 1'b1; Xin = x; Yin = y;
    for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0; Xin = 24'($urandom); Yin = 24'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Xin = '0; Yin = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready, out_valid, QUOTIENT, sticky, div_by_zero, ovf} !== {1'b1, 1'b0, 26'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b vld=%b q=%h st=%b dz=%b ov=%b, want rdy=1 vld=0 q=0 flags=0",
               in_ready, out_valid, QUOTIENT, sticky, div_by_zero, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_unity();
    int lat;
    do_op(24'h800000, 24'h800000, lat);
    checks++;
    if (lat !== 26) begin errors++; $display("FAIL unity_latency: got %0d, want 26", lat); end
    checks++;
    if ({QUOTIENT, sticky, div_by_zero, ovf} !== {26'h2000000, 3'b000}) begin
      errors++;
      $display("FAIL unity_result: got q=%h st=%b dz=%b ov=%b, want q=2000000 flags=0", QUOTIENT, sticky, div_by_zero, ovf);
    end
    consume();
  endtask

  task automatic test_one_half();
    int lat;
    do_op(24'hC00000, 24'h800000, lat);
    checks++;
    if ({lat == 26, QUOTIENT, sticky, div_by_zero, ovf} !== {1'b1, 26'h3000000, 3'b000}) begin
      errors++;
      $display("FAIL one_half: got lat=%0d q=%h st=%b dz=%b ov=%b, want lat=26 q=3000000 flags=0", lat, QUOTIENT, sticky, div_by_zero, ovf);
    end
    consume();
  endtask

  task automatic test_inexact();
    int lat;
    do_op(24'h800000, 24'hC00000, lat);
    checks++;
    if ({lat == 26, QUOTIENT, sticky, div_by_zero, ovf} !== {1'b1, 26'h1555555, 3'b100}) begin
      errors++;
      $display("FAIL inexact: got lat=%0d q=%h st=%b dz=%b ov=%b, want lat=26 q=1555555 st=1", lat, QUOTIENT, sticky, div_by_zero, ovf);
    end
    consume();
  endtask

  task automatic test_div_by_zero();
    int lat;
    do_op(24'h900000, 24'h000000, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d, want 1", lat); end
    checks++;
    if ({QUOTIENT, sticky, div_by_zero, ovf} !== {26'h3FFFFFF, 3'b010}) begin
      errors++;
      $display("FAIL dbz_result: got q=%h st=%b dz=%b ov=%b, want q=3ffffff dz=1", QUOTIENT, sticky, div_by_zero, ovf);
    end
    consume();
  endtask

  task automatic test_ovf();
    int lat;
    do_op(24'hFFFFFF, 24'h7FFFFF, lat);
    checks++;
    if ({lat == 1, QUOTIENT, sticky, div_by_zero, ovf} !== {1'b1, 26'h3FFFFFF, 3'b001}) begin
      errors++;
      $display("FAIL ovf_result: got lat=%0d q=%h st=%b dz=%b ov=%b, want lat=1 q=3ffffff ov=1", lat, QUOTIENT, sticky, div_by_zero, ovf);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat, bad;
    do_op(24'h800000, 24'hC00000, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; Xin = 24'hC00000; Yin = 24'h800000;
      if ({out_valid, in_ready, QUOTIENT, sticky} !== {1'b1, 1'b0, 26'h1555555, 1'b1}) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL backpressure_hold: got %0d unstable cycles, want 0", bad); end
    consume();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
    do_op(24'hC00000, 24'h800000, lat);
    checks++;
    if ({lat == 26, QUOTIENT} !== {1'b1, 26'h3000000}) begin
      errors++;
      $display("FAIL backpressure_next: got lat=%0d q=%h, want lat=26 q=3000000", lat, QUOTIENT);
    end
    consume();
  endtask

  task automatic test_reset_mid_calc();
    int lat, stale;
    @(negedge clk);
    in_valid = 1'b1; Xin = 24'hC00000; Yin = 24'h800000;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, QUOTIENT, sticky, div_by_zero, ovf} !== {1'b1, 1'b0, 26'h0, 3'b000}) begin
      errors++;
      $display("FAIL midcalc_reset: got rdy=%b vld=%b q=%h st=%b dz=%b ov=%b, want rdy=1 vld=0 q=0 flags=0",
               in_ready, out_valid, QUOTIENT, sticky, div_by_zero, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    stale = 0;
    repeat (30) begin @(negedge clk); if (out_valid !== 1'b0) stale++; end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL midcalc_stale: got %0d valid cycles, want 0", stale); end
    do_op(24'hC00000, 24'h800000, lat);
    checks++;
    if ({lat == 26, QUOTIENT, sticky} !== {1'b1, 26'h3000000, 1'b0}) begin
      errors++;
      $display("FAIL midcalc_next: got lat=%0d q=%h st=%b, want lat=26 q=3000000 st=0", lat, QUOTIENT, sticky);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int acc0, acc1, nvld;
    logic [25:0] q_seen;
    acc0 = -1; acc1 = -1; nvld = 0; q_seen = '0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; Xin = 24'hC00000; Yin = 24'h800000;
    for (int c = 0; c < 100 && acc1 < 0; c++) begin
      if (out_valid) begin nvld++; q_seen = QUOTIENT; end
      if (in_ready && in_valid) begin
        if (acc0 < 0) acc0 = c; else acc1 = c;
      end
      if (acc1 < 0) @(negedge clk);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (acc1 - acc0 !== 27) begin errors++; $display("FAIL b2b_period: got %0d, want 27", acc1 - acc0); end
    checks++;
    if ({nvld, q_seen} !== {32'd1, 26'h3000000}) begin
      errors++;
      $display("FAIL b2b_result: got %0d valid cycles q=%h, want 1 q=3000000", nvld, q_seen);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain: got rdy=%b, want 1", in_ready); end
  endtask

  task automatic test_random();
    int lat, bad;
    logic [23:0] x, y;
    logic [48:0] num, q_ref, r_ref;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      x = 24'($urandom_range(24'hFFFFFF, 24'h800000));
      y = 24'($urandom_range(24'hFFFFFF, 24'h800000));
      num   = {1'b0, x, 24'h0} << 1;
      q_ref = num / {25'h0, y};
      r_ref = num - q_ref * {25'h0, y};
      do_op(x, y, lat);
      checks++;
      if ({lat == 26, QUOTIENT, sticky, div_by_zero, ovf} !== {1'b1, q_ref[25:0], r_ref != 0, 2'b00}) begin
        errors++;
        if (bad < 10)
          $display("FAIL random %h/%h: got lat=%0d q=%h st=%b dz=%b ov=%b, want q=%h st=%b",
                   x, y, lat, QUOTIENT, sticky, div_by_zero, ovf, q_ref[25:0], r_ref != 0);
        bad++;
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_one_half();
    test_inexact();
    test_div_by_zero();
    test_ovf();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
